// File: rtl/printer_cmd_pkg.sv
// Shared types and widths for the printer command path: command codes,
// dispatcher FSM states and the queued command record.
package printer_cmd_pkg;

  localparam int AXIS_W     = 32;
  localparam int NUM_AXES   = 5;
  localparam int FIFO_DEPTH = 2;
  localparam int DATA_W     = 32;
  localparam int CODE_W     = 3;
  localparam int AXES_W     = AXIS_W * NUM_AXES;
  localparam int ENTRY_W    = CODE_W + AXES_W + 3 * DATA_W;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_MOVE = 3'd1,
    CMD_HEAT = 3'd2,
    CMD_HOME = 3'd3,
    CMD_STOP = 3'd4
  } cmd_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } disp_state_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [AXES_W-1:0] axes;
    logic [DATA_W-1:0] f;
    logic [DATA_W-1:0] t;
    logic [DATA_W-1:0] dt;
  } cmd_entry_t;

  // Codes 5..7 are reserved and rejected at the request port.
  function automatic logic code_valid(input logic [CODE_W-1:0] code);
    return code <= 3'd4;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Two-entry command queue with synchronous flush. Simultaneous push and pop
// both take effect; pushes into a full queue are dropped.
module cmd_fifo
  import printer_cmd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] dout,
  output logic               empty,
  output logic               full
);

  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/command_dispatcher.sv
// Accepts toggle-handshaked commands from the HPS, queues them, and runs one
// executor at a time through IDLE -> ISSUE -> WAIT. STOP bypasses the queue.
module command_dispatcher
  import printer_cmd_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_req_tgl,
  input  logic         err_clr,
  input  logic [31:0]  cmd_type,
  input  logic [159:0] cmd_axes,
  input  logic [31:0]  cmd_f,
  input  logic [31:0]  cmd_t,
  input  logic [31:0]  cmd_dt,
  output logic         cmd_ack_tgl,
  output logic [15:0]  status,
  output logic         move_start,
  output logic         home_start,
  output logic         heat_start,
  output logic [159:0] move_axes,
  output logic [31:0]  move_f,
  output logic [31:0]  heat_t,
  output logic [31:0]  heat_dt,
  input  logic         move_done,
  input  logic         home_done,
  input  logic         heat_done,
  output logic         abort,
  output logic [1:0]   state_dbg
);

  // Handshake: a request is pending while cmd_req_tgl differs from
  // cmd_ack_tgl; the dispatcher flips cmd_ack_tgl in the cycle it consumes it.
  disp_state_e   state_q, state_d;
  logic [2:0]    cur_code_q, cur_code_d;
  logic          ack_q, ack_d;
  logic          error_q, error_d;
  logic          abort_q, abort_d;
  logic [7:0]    done_cnt_q, done_cnt_d;
  logic [159:0]  move_axes_q, move_axes_d;
  logic [31:0]   move_f_q, move_f_d;
  logic [31:0]   heat_t_q, heat_t_d;
  logic [31:0]   heat_dt_q, heat_dt_d;

  logic          req_pending, is_stop, req_valid, accept, stop_now, push, pop;
  logic [2:0]    req_code;
  logic          fifo_empty, fifo_full;
  cmd_entry_t    wr_entry, head;
  logic [ENTRY_W-1:0] fifo_dout;
  logic          unused_cmd_type;

  assign unused_cmd_type = ^cmd_type[31:3];
  assign req_code    = cmd_type[2:0];
  assign req_pending = cmd_req_tgl ^ ack_q;
  assign is_stop     = (req_code == CMD_STOP);
  assign req_valid   = code_valid(req_code);
  assign accept      = req_pending && (!fifo_full || is_stop);
  assign stop_now    = accept && is_stop;
  assign push        = accept && req_valid && !is_stop;

  assign wr_entry.code = req_code;
  assign wr_entry.axes = cmd_axes;
  assign wr_entry.f    = cmd_f;
  assign wr_entry.t    = cmd_t;
  assign wr_entry.dt   = cmd_dt;
  assign head          = fifo_dout;

  cmd_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (stop_now),
    .din   (wr_entry),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Error clear loses to a fresh invalid code arriving in the same cycle.
  assign ack_d   = ack_q ^ accept;
  assign error_d = (error_q && !err_clr) || (accept && !req_valid);
  assign abort_d = stop_now;

  always_comb begin
    state_d     = state_q;
    cur_code_d  = cur_code_q;
    done_cnt_d  = done_cnt_q;
    move_axes_d = move_axes_q;
    move_f_d    = move_f_q;
    heat_t_d    = heat_t_q;
    heat_dt_d   = heat_dt_q;
    pop         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.code == CMD_NOP) begin
            done_cnt_d = done_cnt_q + 8'd1;
          end else begin
            cur_code_d = head.code;
            state_d    = ST_ISSUE;
            if (head.code == CMD_MOVE) begin
              move_axes_d = head.axes;
              move_f_d    = head.f;
            end
            if (head.code == CMD_HEAT) begin
              heat_t_d  = head.t;
              heat_dt_d = head.dt;
            end
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if ((cur_code_q == CMD_MOVE && move_done) ||
            (cur_code_q == CMD_HOME && home_done) ||
            (cur_code_q == CMD_HEAT && heat_done)) begin
          done_cnt_d = done_cnt_q + 8'd1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // STOP wins over any completion or pop in the same cycle.
    if (stop_now) begin
      state_d     = ST_IDLE;
      cur_code_d  = cur_code_q;
      done_cnt_d  = done_cnt_q;
      move_axes_d = move_axes_q;
      move_f_d    = move_f_q;
      heat_t_d    = heat_t_q;
      heat_dt_d   = heat_dt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_code_q  <= CMD_NOP;
      ack_q       <= 1'b0;
      error_q     <= 1'b0;
      abort_q     <= 1'b0;
      done_cnt_q  <= 8'd0;
      move_axes_q <= '0;
      move_f_q    <= '0;
      heat_t_q    <= '0;
      heat_dt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_code_q  <= cur_code_d;
      ack_q       <= ack_d;
      error_q     <= error_d;
      abort_q     <= abort_d;
      done_cnt_q  <= done_cnt_d;
      move_axes_q <= move_axes_d;
      move_f_q    <= move_f_d;
      heat_t_q    <= heat_t_d;
      heat_dt_q   <= heat_dt_d;
    end
  end

  assign cmd_ack_tgl = ack_q;
  assign abort       = abort_q;
  assign move_start  = (state_q == ST_ISSUE) && (cur_code_q == CMD_MOVE);
  assign home_start  = (state_q == ST_ISSUE) && (cur_code_q == CMD_HOME);
  assign heat_start  = (state_q == ST_ISSUE) && (cur_code_q == CMD_HEAT);
  assign move_axes   = move_axes_q;
  assign move_f      = move_f_q;
  assign heat_t      = heat_t_q;
  assign heat_dt     = heat_dt_q;
  assign state_dbg   = state_q;
  assign status      = {done_cnt_q, 4'b0000, error_q,
                        (state_q != ST_IDLE) || !fifo_empty, fifo_full, ack_q};

endmodule

// File: tb/tb_command_dispatcher.sv
// Directed bench for command_dispatcher: handshake, queueing, STOP, errors,
// counter wrap and done-pulse filtering.
module tb_command_dispatcher;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_req_tgl = 1'b0;
  logic         err_clr = 1'b0;
  logic [31:0]  cmd_type = '0;
  logic [159:0] cmd_axes = '0;
  logic [31:0]  cmd_f = '0, cmd_t = '0, cmd_dt = '0;
  logic         cmd_ack_tgl;
  logic [15:0]  status;
  logic         move_start, home_start, heat_start;
  logic [159:0] move_axes;
  logic [31:0]  move_f, heat_t, heat_dt;
  logic         move_done = 1'b0, home_done = 1'b0, heat_done = 1'b0;
  logic         abort;
  logic [1:0]   state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int n_move_start = 0, n_home_start = 0, n_heat_start = 0, n_abort = 0;
  int base_move, base_heat;

  command_dispatcher dut (
    .clk(clk), .reset(reset), .cmd_req_tgl(cmd_req_tgl), .err_clr(err_clr),
    .cmd_type(cmd_type), .cmd_axes(cmd_axes), .cmd_f(cmd_f), .cmd_t(cmd_t),
    .cmd_dt(cmd_dt), .cmd_ack_tgl(cmd_ack_tgl), .status(status),
    .move_start(move_start), .home_start(home_start), .heat_start(heat_start),
    .move_axes(move_axes), .move_f(move_f), .heat_t(heat_t), .heat_dt(heat_dt),
    .move_done(move_done), .home_done(home_done), .heat_done(heat_done),
    .abort(abort), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (move_start) n_move_start++;
    if (home_start) n_home_start++;
    if (heat_start) n_heat_start++;
    if (abort)      n_abort++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] code, input logic [31:0] x,
                      input logic [31:0] f, input logic [31:0] t, input logic [31:0] dt);
    cmd_type    = code;
    cmd_axes    = {128'd0, x};
    cmd_f       = f;
    cmd_t       = t;
    cmd_dt      = dt;
    cmd_req_tgl = ~cmd_req_tgl;
  endtask

  task automatic wait_move_start(input logic [31:0] exp_x);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (move_start) found = 1'b1;
      else tick();
    end
    check("move_start_seen", found, 1'b1);
    check("move_axes_x", move_axes[31:0], exp_x);
  endtask

  task automatic pulse_move_done();
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_status", status, 16'h0000);
    check("rst_ack", cmd_ack_tgl, 1'b0);
    check("rst_state", state_dbg, 2'd0);
    check("rst_axes", move_axes, 160'd0);
    check("rst_heat_t", heat_t, 32'd0);
    check("rst_abort", abort, 1'b0);

    // Scenario 1: single MOVE
    send(1, 100, 1500, 0, 0);
    tick();
    check("s1_ack", cmd_ack_tgl, 1'b1);
    check("s1_status_queued", status, 16'h0005);
    tick();
    check("s1_move_start", move_start, 1'b1);
    check("s1_move_axes", move_axes, {128'd0, 32'd100});
    check("s1_move_f", move_f, 32'd1500);
    check("s1_state_issue", state_dbg, 2'd1);
    tick();
    check("s1_start_one_cycle", move_start, 1'b0);
    check("s1_state_wait", state_dbg, 2'd2);
    pulse_move_done();
    check("s1_status_done", status, 16'h0101);
    check("s1_state_idle", state_dbg, 2'd0);
    check("s1_move_count", n_move_start, 1);

    // Scenario 2: HEAT in flight, queue fills, third request held
    send(2, 0, 0, 210, 0);
    tick();
    tick();
    check("s2_heat_start", heat_start, 1'b1);
    check("s2_heat_t", heat_t, 32'd210);
    check("s2_heat_dt", heat_dt, 32'd0);
    tick();
    send(1, 5, 0, 0, 0);
    tick();
    send(1, 6, 0, 0, 0);
    tick();
    check("s2_full", status, 16'h0106);
    send(1, 7, 0, 0, 0);
    tick();
    tick();
    check("s2_ack_held", cmd_ack_tgl, 1'b0);
    check("s2_full_held", status, 16'h0106);
    heat_done = 1'b1;
    tick();
    heat_done = 1'b0;
    check("s2_after_heat_done", status, 16'h0206);
    check("s2_idle", state_dbg, 2'd0);
    tick();
    check("s2_pop_status", status, 16'h0204);
    check("s2_move5_start", move_start, 1'b1);
    check("s2_move5_axes", move_axes, {128'd0, 32'd5});
    tick();
    check("s2_third_accepted", status, 16'h0207);
    check("s2_wait", state_dbg, 2'd2);
    pulse_move_done();
    wait_move_start(6);
    tick();
    pulse_move_done();
    wait_move_start(7);
    tick();
    pulse_move_done();
    tick();
    check("s2_drained", status, 16'h0501);

    // Scenario 3: invalid code and sticky error
    base_move = n_move_start;
    base_heat = n_heat_start;
    send(6, 0, 0, 0, 0);
    tick();
    check("s3_error_set", status, 16'h0508);
    repeat (3) tick();
    check("s3_no_move", n_move_start, base_move);
    check("s3_no_heat", n_heat_start, base_heat);
    check("s3_no_home", n_home_start, 0);
    err_clr = 1'b1;
    send(7, 0, 0, 0, 0);
    tick();
    err_clr = 1'b0;
    check("s3_clr_vs_invalid", status, 16'h0509);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("s3_error_cleared", status, 16'h0501);

    // Scenario 4: STOP while full, colliding with move_done
    send(1, 9, 0, 0, 0);
    tick();
    wait_move_start(9);
    tick();
    check("s4_wait", state_dbg, 2'd2);
    send(3, 0, 0, 0, 0);
    tick();
    send(2, 0, 0, 50, 1);
    tick();
    check("s4_full", status, 16'h0506);
    send(4, 0, 0, 0, 0);
    move_done = 1'b1;
    tick();
    move_done = 1'b0;
    check("s4_abort", abort, 1'b1);
    check("s4_status", status, 16'h0501);
    check("s4_idle", state_dbg, 2'd0);
    tick();
    check("s4_abort_one_cycle", abort, 1'b0);
    repeat (4) tick();
    check("s4_no_home", n_home_start, 0);
    check("s4_no_heat", n_heat_start, base_heat);
    check("s4_abort_count", n_abort, 1);

    // Reset during WAIT drops the command silently
    send(1, 11, 0, 0, 0);
    tick();
    wait_move_start(11);
    tick();
    check("rw_wait", state_dbg, 2'd2);
    reset = 1'b1;
    cmd_req_tgl = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rw_status", status, 16'h0000);
    check("rw_state", state_dbg, 2'd0);
    check("rw_axes", move_axes, 160'd0);
    check("rw_no_abort", n_abort, 1);

    // Scenario 5: 256 NOPs wrap done_cnt
    base_move = n_move_start;
    for (int i = 0; i < 255; i++) begin
      send(0, 0, 0, 0, 0);
      tick();
    end
    tick();
    tick();
    check("s5_cnt_255", status, 16'hFF01);
    send(0, 0, 0, 0, 0);
    tick();
    tick();
    check("s5_cnt_wrap", status, 16'h0000);
    check("s5_no_start", n_move_start, base_move);

    // Scenario 6: foreign done pulses ignored during MOVE
    send(1, 20, 0, 0, 0);
    tick();
    wait_move_start(20);
    tick();
    home_done = 1'b1;
    heat_done = 1'b1;
    tick();
    home_done = 1'b0;
    heat_done = 1'b0;
    check("s6_still_wait", state_dbg, 2'd2);
    check("s6_status", status, 16'h0005);
    pulse_move_done();
    check("s6_done", status, 16'h0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
